// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner of a shared tri-state bus: bounded tenures, high-Z turnaround between owners.
// Grant one edge after a request is seen in IDLE; requesters simply wait (level req), no data is queued.
module tristate_bus_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int WIDTH      = 8,
  parameter int MAX_HOLD   = 4,
  parameter int TURNAROUND = 1,
  localparam int OW        = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       req,
  input  logic [NUM_CH*WIDTH-1:0] din,
  output logic [NUM_CH-1:0]       grant,
  output logic [NUM_CH-1:0]       oe_n,
  output tri   [WIDTH-1:0]        data_bus,
  output logic                    bus_busy,
  output logic [OW-1:0]           owner
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int TW = (TURNAROUND > 1) ? $clog2(TURNAROUND + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_CH-1:0]   grant_q, grant_d;
  logic [NUM_CH-1:0]   oe_n_q;
  logic [OW-1:0]       owner_q, owner_d;
  logic [OW-1:0]       rr_q, rr_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [TW-1:0]       turn_q, turn_d;
  logic                busy_q;

  logic                pick_vld;
  logic [OW-1:0]       pick_idx;
  logic                owner_req;
  logic                others_req;
  logic                release_bus;

  logic [WIDTH-1:0]    din_ch [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_din
    assign din_ch[k] = din[k*WIDTH +: WIDTH];
  end

  // Scan from rr_q upward with wrap; iterating backwards lets the closest requester win.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      logic [OW-1:0] cand;
      cand = OW'((int'(rr_q) + i) % NUM_CH);
      if (req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // grant_q is one-hot on the owner while driving, so masking with it isolates the owner.
  assign owner_req   = |(req & grant_q);
  assign others_req  = |(req & ~grant_q);
  assign release_bus = !owner_req || ((hold_q == HW'(MAX_HOLD)) && others_req);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    turn_d  = turn_q;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = DRIVE;
          grant_d = NUM_CH'(1) << pick_idx;
          owner_d = pick_idx;
          hold_d  = HW'(1);
        end
      end

      DRIVE: begin
        if (release_bus) begin
          state_d = TURN;
          grant_d = '0;
          rr_d    = (owner_q == OW'(NUM_CH - 1)) ? '0 : owner_q + OW'(1);
          turn_d  = TW'(1);
        end else if (hold_q != HW'(MAX_HOLD)) begin
          hold_d = hold_q + HW'(1);
        end
      end

      TURN: begin
        if (turn_q == TW'(TURNAROUND)) begin
          if (pick_vld) begin
            state_d = DRIVE;
            grant_d = NUM_CH'(1) << pick_idx;
            owner_d = pick_idx;
            hold_d  = HW'(1);
          end else begin
            state_d = IDLE;
          end
        end else begin
          turn_d = turn_q + TW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      oe_n_q  <= '1;
      owner_q <= '0;
      rr_q    <= '0;
      hold_q  <= '0;
      turn_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      oe_n_q  <= ~grant_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign grant    = grant_q;
  assign oe_n     = oe_n_q;
  assign owner    = owner_q;
  assign bus_busy = busy_q;

  // bufif0: the owner's enable (active low) gates its data onto the shared bus.
  assign data_bus = oe_n_q[owner_q] ? {WIDTH{1'bz}} : din_ch[owner_q];

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Bench for tristate_bus_arbiter: directed scenarios plus random traffic against a tenure/gap model.
module tb_tristate_bus_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req;
  logic [N*W-1:0]   din;

  logic [N-1:0]     grant_a, oe_n_a, grant_b, oe_n_b;
  wire  [W-1:0]     bus_a, bus_b;
  logic             busy_a, busy_b;
  logic [1:0]       owner_a, owner_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: current owner (-1 none), last owner, rotation pointer, cycles held, Z cycles left.
  int m_own  [2];
  int m_last [2];
  int m_ptr  [2];
  int m_ten  [2];
  int m_gap  [2];
  int m_ta   [2];

  tristate_bus_arbiter #(.NUM_CH(N), .WIDTH(W), .MAX_HOLD(MH), .TURNAROUND(1)) dut_a (
    .clk(clk), .reset(reset), .req(req), .din(din), .grant(grant_a), .oe_n(oe_n_a),
    .data_bus(bus_a), .bus_busy(busy_a), .owner(owner_a)
  );

  tristate_bus_arbiter #(.NUM_CH(N), .WIDTH(W), .MAX_HOLD(MH), .TURNAROUND(3)) dut_b (
    .clk(clk), .reset(reset), .req(req), .din(din), .grant(grant_b), .oe_n(oe_n_b),
    .data_bus(bus_b), .bus_busy(busy_b), .owner(owner_b)
  );

  always #5 clk = ~clk;

  task automatic m_arb(input int i);
    m_own[i] = -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr[i] + k) % N;
      if (req[c] && m_own[i] < 0) begin
        m_own[i]  = c;
        m_last[i] = c;
        m_ten[i]  = 1;
      end
    end
  endtask

  task automatic m_step(input int i);
    logic [N-1:0] oth;
    if (reset) begin
      m_own[i] = -1; m_last[i] = 0; m_ptr[i] = 0; m_ten[i] = 0; m_gap[i] = 0;
    end else if (m_own[i] >= 0) begin
      oth = req;
      oth[m_own[i]] = 1'b0;
      if (!req[m_own[i]] || (m_ten[i] >= MH && oth != 0)) begin
        m_ptr[i] = (m_own[i] + 1) % N;
        m_own[i] = -1;
        m_gap[i] = m_ta[i];
      end else begin
        m_ten[i]++;
      end
    end else if (m_gap[i] > 1) begin
      m_gap[i]--;
    end else begin
      m_gap[i] = 0;
      m_arb(i);
    end
  endtask

  function automatic logic [N-1:0] m_grant(input int i);
    return (m_own[i] >= 0) ? (N'(1) << m_own[i]) : '0;
  endfunction

  function automatic logic m_busy(input int i);
    return (m_own[i] >= 0) || (m_gap[i] > 0);
  endfunction

  function automatic logic [1:0] m_owner(input int i);
    return 2'(m_last[i]);
  endfunction

  function automatic logic [W-1:0] m_data(input int i);
    if (m_own[i] < 0) return '0;
    return din[m_own[i]*W +: W];
  endfunction

  task automatic tick();
    @(posedge clk);
    m_step(0);
    m_step(1);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b1111;
    din   = 32'h44_33_22_11;
    tick();
    tick();
    n_checks++; if (grant_a !== 4'b0000) begin n_fail++; $display("FAIL reset_grant actual=%b required=0000", grant_a); end
    n_checks++; if (oe_n_a !== 4'b1111) begin n_fail++; $display("FAIL reset_oe_n actual=%b required=1111", oe_n_a); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy actual=%b required=0", busy_a); end
    n_checks++; if (owner_a !== 2'd0) begin n_fail++; $display("FAIL reset_owner actual=%0d required=0", owner_a); end
    reset = 1'b0;
    tick();
    n_checks++; if (grant_a !== m_grant(0)) begin n_fail++; $display("FAIL reset_first_grant actual=%b required=%b", grant_a, m_grant(0)); end
    n_checks++; if (bus_a !== m_data(0)) begin n_fail++; $display("FAIL reset_first_data actual=%h required=%h", bus_a, m_data(0)); end
  endtask

  task automatic test_single();
    do_reset();
    din = 32'h00_A5_00_00;
    req = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++; if (grant_a !== m_grant(0)) begin n_fail++; $display("FAIL single_grant cyc=%0d actual=%b required=%b", c, grant_a, m_grant(0)); end
      n_checks++; if (oe_n_a !== ~m_grant(0)) begin n_fail++; $display("FAIL single_oe_n cyc=%0d actual=%b required=%b", c, oe_n_a, ~m_grant(0)); end
      if (m_own[0] >= 0) begin
        n_checks++; if (bus_a !== 8'hA5) begin n_fail++; $display("FAIL single_data cyc=%0d actual=%h required=a5", c, bus_a); end
      end
    end
    req = 4'b0000;
    tick();
    n_checks++; if (grant_a !== 4'b0000 || busy_a !== 1'b1) begin n_fail++; $display("FAIL single_turn actual=%b/%b required=0000/1", grant_a, busy_a); end
    tick();
    n_checks++; if (busy_a !== m_busy(0)) begin n_fail++; $display("FAIL single_idle actual=%b required=%b", busy_a, m_busy(0)); end
  endtask

  task automatic test_round_robin();
    int starts[$];
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] prev = '0;
    do_reset();
    din = 32'hD3_C2_B1_A0;
    req = 4'b1111;
    for (int c = 0; c < 25; c++) begin
      tick();
      n_checks++; if (grant_a !== m_grant(0)) begin n_fail++; $display("FAIL rr_grant cyc=%0d actual=%b required=%b", c, grant_a, m_grant(0)); end
      n_checks++; if (owner_a !== m_owner(0)) begin n_fail++; $display("FAIL rr_owner cyc=%0d actual=%0d required=%0d", c, owner_a, m_owner(0)); end
      n_checks++; if ($countones(~oe_n_a) > 1) begin n_fail++; $display("FAIL rr_overlap cyc=%0d actual=%b required=at most one low", c, oe_n_a); end
      if (m_own[0] >= 0) begin
        n_checks++; if (bus_a !== m_data(0)) begin n_fail++; $display("FAIL rr_data cyc=%0d actual=%h required=%h", c, bus_a, m_data(0)); end
      end
      if (grant_a != 0 && prev == 0) starts.push_back(int'(owner_a));
      prev = grant_a;
    end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (k >= starts.size()) begin n_fail++; $display("FAIL rr_sequence idx=%0d actual=none required=%0d", k, exp_seq[k]); end
      else if (starts[k] != exp_seq[k]) begin n_fail++; $display("FAIL rr_sequence idx=%0d actual=%0d required=%0d", k, starts[k], exp_seq[k]); end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    din = 32'h99_88_77_66;
    req = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) req = 4'b1000;
      tick();
      n_checks++; if (grant_a !== m_grant(0)) begin n_fail++; $display("FAIL early_grant cyc=%0d actual=%b required=%b", c, grant_a, m_grant(0)); end
      n_checks++; if (busy_a !== m_busy(0)) begin n_fail++; $display("FAIL early_busy cyc=%0d actual=%b required=%b", c, busy_a, m_busy(0)); end
    end
    n_checks++; if (grant_a !== 4'b1000) begin n_fail++; $display("FAIL early_final actual=%b required=1000", grant_a); end
    n_checks++; if (bus_a !== 8'h99) begin n_fail++; $display("FAIL early_data actual=%h required=99", bus_a); end
  endtask

  task automatic test_turnaround();
    int z_run = 0;
    do_reset();
    din = 32'h00_00_5C_3A;
    req = 4'b0011;
    for (int c = 0; c < 22; c++) begin
      tick();
      n_checks++; if (grant_b !== m_grant(1)) begin n_fail++; $display("FAIL ta_grant cyc=%0d actual=%b required=%b", c, grant_b, m_grant(1)); end
      n_checks++; if (busy_b !== m_busy(1)) begin n_fail++; $display("FAIL ta_busy cyc=%0d actual=%b required=%b", c, busy_b, m_busy(1)); end
      n_checks++; if (owner_b !== m_owner(1)) begin n_fail++; $display("FAIL ta_owner cyc=%0d actual=%0d required=%0d", c, owner_b, m_owner(1)); end
      if (m_own[1] >= 0) begin
        n_checks++; if (bus_b !== m_data(1)) begin n_fail++; $display("FAIL ta_data cyc=%0d actual=%h required=%h", c, bus_b, m_data(1)); end
      end
      if (grant_b == 0 && busy_b) z_run++;
      else if (grant_b != 0 && z_run > 0) begin
        n_checks++; if (z_run != 3) begin n_fail++; $display("FAIL ta_gap cyc=%0d actual=%0d required=3", c, z_run); end
        z_run = 0;
      end
    end
  endtask

  task automatic test_reset_mid_drive();
    do_reset();
    din = 32'h00_7E_00_00;
    req = 4'b0100;
    tick();
    tick();
    n_checks++; if (grant_a !== 4'b0100) begin n_fail++; $display("FAIL mid_pre actual=%b required=0100", grant_a); end
    reset = 1'b1;
    tick();
    n_checks++; if (grant_a !== 4'b0000 || oe_n_a !== 4'b1111) begin n_fail++; $display("FAIL mid_release actual=%b/%b required=0000/1111", grant_a, oe_n_a); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL mid_busy actual=%b required=0", busy_a); end
    reset = 1'b0;
    req   = 4'b1111;
    tick();
    n_checks++; if (grant_a !== 4'b0001) begin n_fail++; $display("FAIL mid_restart actual=%b required=0001", grant_a); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 79) == 0);
      req   = 4'($urandom);
      din   = $urandom;
      tick();
      n_checks++; if (grant_a !== m_grant(0) || grant_b !== m_grant(1)) begin n_fail++; $display("FAIL rnd_grant cyc=%0d actual=%b/%b required=%b/%b", c, grant_a, grant_b, m_grant(0), m_grant(1)); end
      n_checks++; if (oe_n_a !== ~m_grant(0) || oe_n_b !== ~m_grant(1)) begin n_fail++; $display("FAIL rnd_oe_n cyc=%0d actual=%b/%b", c, oe_n_a, oe_n_b); end
      n_checks++; if (busy_a !== m_busy(0) || busy_b !== m_busy(1)) begin n_fail++; $display("FAIL rnd_busy cyc=%0d actual=%b/%b required=%b/%b", c, busy_a, busy_b, m_busy(0), m_busy(1)); end
      n_checks++; if (owner_a !== m_owner(0) || owner_b !== m_owner(1)) begin n_fail++; $display("FAIL rnd_owner cyc=%0d actual=%0d/%0d required=%0d/%0d", c, owner_a, owner_b, m_owner(0), m_owner(1)); end
      if (m_own[0] >= 0) begin
        n_checks++; if (bus_a !== m_data(0)) begin n_fail++; $display("FAIL rnd_data_a cyc=%0d actual=%h required=%h", c, bus_a, m_data(0)); end
      end
      if (m_own[1] >= 0) begin
        n_checks++; if (bus_b !== m_data(1)) begin n_fail++; $display("FAIL rnd_data_b cyc=%0d actual=%h required=%h", c, bus_b, m_data(1)); end
      end
    end
  endtask

  initial begin
    m_ta[0] = 1;
    m_ta[1] = 3;
    for (int i = 0; i < 2; i++) begin
      m_own[i] = -1; m_last[i] = 0; m_ptr[i] = 0; m_ten[i] = 0; m_gap[i] = 0;
    end
    reset = 1'b1;
    req   = '0;
    din   = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_early_release();
    test_turnaround();
    test_reset_mid_drive();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
